// File: rtl/pipeline_pkg.sv
// pipeline_pkg: opcodes, instruction field positions and writeback state shared across the pipeline
package pipeline_pkg;
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LD     = 4'h8;
  localparam logic [3:0] OP_ST     = 4'h9;
  localparam logic [3:0] OP_BEQ    = 4'hA;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 12;
  typedef enum logic {WB_RUN, WB_HALTED} wb_state_t;
  function automatic logic writes_rd(input logic [3:0] op);
    return (op >= OP_ALU_LO && op <= OP_ALU_HI) || op == OP_LD;
  endfunction
endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM-stage inputs and register-file write port of the writeback stage
interface writeback_stage_if #(parameter int DATA_W = 16, parameter int INSTR_W = 20);
  logic               valid_in;
  logic               stall;
  logic               flush;
  logic [INSTR_W-1:0] instruction_in;
  logic [3:0]         opcode_in;
  logic [DATA_W-1:0]  alu_result;
  logic [DATA_W-1:0]  mem_data;
  logic               rf_we;
  logic [3:0]         rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  modport master (
    output valid_in, stall, flush, instruction_in, opcode_in, alu_result, mem_data,
    input  rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    input  valid_in, stall, flush, instruction_in, opcode_in, alu_result, mem_data,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/writeback_stage_retire_counter.sv
// retire_counter: wrapping retired-instruction counter; freezing is done by holding en low
module retire_counter #(parameter int CNT_W = 16) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, register-file write port, retire count and HALT tracking.
// Define WB_FORWARD_EN to add the fwd_valid/fwd_addr/fwd_data bypass outputs.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 20,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  writeback_stage_if.slave wb,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [3:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);
  wb_state_t         state, state_nxt;
  logic              wb_valid;
  logic [3:0]        wb_op;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              run;
  logic              take;
  logic              unused_bits;
  assign run  = state == WB_RUN;
  assign take = run & wb.valid_in & ~wb.flush & ~wb.stall;
  // opcode_in is authoritative, so the instruction's own opcode field is ignored
  assign unused_bits = ^{wb.instruction_in[OPC_MSB:OPC_LSB], wb.instruction_in[RD_LSB-1:0]};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_op    <= OP_NOP;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= take;
      if (take) begin
        wb_op   <= wb.opcode_in;
        wb_rd   <= wb.instruction_in[RD_MSB:RD_LSB];
        wb_data <= wb.opcode_in == OP_LD ? wb.mem_data : wb.alu_result;
      end
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= WB_RUN;
    else state <= state_nxt;
  always_comb state_nxt = (run && wb_valid && wb_op == OP_HALT) ? WB_HALTED : state;
  assign halted      = ~run;
  assign wb.rf_we    = run & wb_valid & writes_rd(wb_op) & (wb_rd != '0);
  assign wb.rf_waddr = wb_rd;
  assign wb.rf_wdata = wb_data;
`ifdef WB_FORWARD_EN
  assign fwd_valid = wb.rf_we;
  assign fwd_addr  = wb_rd;
  assign fwd_data  = wb_data;
`endif
  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clock (clock),
    .reset (reset),
    .en    (run & wb_valid),
    .count (retired_count)
  );
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Write side of the register file in the 16-bit, 20-bit-instruction pipeline.
- Holds the MEM/WB pipeline register, selects the result, and drives the register-file write port (address, data, enable).
- Tracks retired instructions and halts the pipeline on HALT.
- The ID/EX stage reads the register file; this block is the stage that writes it.

Parameters:
- DATA_W, 16, datapath/register width
- INSTR_W, 20, instruction width
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- valid_in  in  1  MEM stage presents a valid instruction this cycle
- stall  in  1  upstream stalled; insert bubble
- flush  in  1  kill the incoming instruction
- instruction_in  in  INSTR_W  propagated instruction; [19:16] opcode, [15:12] rd
- opcode_in  in  4  propagated opcode (authoritative over instruction_in[19:16])
- alu_result  in  DATA_W  EX result
- mem_data  in  DATA_W  load data from memory
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- halted  out  1  HALT has retired
- retired_count  out  CNT_W  count of retired instructions

Behaviour:
- Reset (reset=0, asynchronous):
  - wb_valid=0, wb_op=NOP, wb_rd=0, wb_data=0
  - state=RUN, retired_count=0
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, halted=0
- Capture, at rising clock edge in RUN:
  - wb_valid <= valid_in & ~flush & ~stall
  - If that term is 1, also load wb_op<=opcode_in, wb_rd<=instruction_in[15:12], wb_data<=(opcode_in==OP_LD ? mem_data : alu_result)
  - Otherwise the payload registers keep their values; only wb_valid clears.
  - Precedence: flush and stall both produce a bubble. Neither is remembered.
- Latency: an instruction presented at edge N drives the write port during cycle N+1, and the register file commits at edge N+1.
- Write port (combinational from the WB register):
  - rf_we = wb_valid & writes_rd(wb_op) & (wb_rd!=0)
  - rf_waddr = wb_rd
  - rf_wdata = wb_data
  - Register 0 is never written.
- writes_rd is true for opcodes 4'h1..4'h7 (ALU) and OP_LD=4'h8. It is false for NOP=4'h0, ST=4'h9, BEQ=4'hA, 4'hB..4'hE and HALT=4'hF.
- Retire: at each edge where wb_valid=1, retired_count increments by 1. It wraps modulo 2^CNT_W, so all-ones goes to 0 with no saturation. NOP, ST and BEQ count as retired when valid.
- FSM states: RUN and HALTED.
  - RUN -> HALTED at the edge where wb_valid=1 and wb_op==HALT. The HALT itself is counted.
  - In HALTED: wb_valid <= 0 every edge, inputs are ignored, rf_we=0, halted=1, and retired_count is frozen.
  - HALTED is exited only by reset.
- Reset mid-operation: a pending writeback is discarded, and rf_we drops immediately (asynchronously).

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined: adds outputs fwd_valid(1), fwd_addr(4) and fwd_data(DATA_W), equal to rf_we, rf_waddr and rf_wdata respectively. The decode stage uses them to bypass a same-cycle write and read of the same register.
  - fwd_valid is 0 in HALTED and in reset.
- Undefined: these ports do not exist. A same-cycle read then returns the old register value, and software or hazard logic must insert one bubble.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode constants OP_NOP, OP_LD, OP_ST, OP_BEQ, OP_HALT and the ALU range
  - field positions OPC_MSB/LSB and RD_MSB/LSB
  - the writes_rd function
  - wb_state_t enum {WB_RUN, WB_HALTED}
- One natural sub-module: retire_counter, covering CNT_W wrap, enable and freeze.

Test Plan:
- Reset:
  - Stimulus: assert reset=0 mid-cycle while rf_we=1.
  - Required: rf_we=0 before the next edge; retired_count=0; halted=0.
- ALU write:
  - Stimulus: opcode 4'h1, rd=3, alu_result=16'h1234, valid_in=1 at edge N.
  - Required: during cycle N+1, rf_we=1, rf_waddr=3, rf_wdata=16'h1234; retired_count=1 after edge N+1.
- Load and r0 suppression:
  - Stimulus: LD with rd=5 and mem_data=16'hBEEF (alu_result=16'h0040), followed by an ALU op with rd=0.
  - Required: first instruction writes 16'hBEEF to r5; second gives rf_we=0; retired_count=2.
- Stall and flush:
  - Stimulus: valid_in=1 with stall=1, then valid_in=1 with flush=1, then ST with rd=2.
  - Required: rf_we=0 for all three; retired_count increments only for ST (+1).
- HALT:
  - Stimulus: ALU, HALT, then ALU with rd=4 on back-to-back edges.
  - Required: halted=1 after HALT retires; the r4 write never occurs; retired_count=2 and stays frozen for 10 cycles.
- Wrap, with CNT_W=4:
  - Stimulus: retire 17 valid NOPs.
  - Required: retired_count=1 (wrapped through 0).
